// File: rtl/alu_accum_ctrl.sv
// rtl/alu_accum_ctrl.sv - accumulator/flag execution controller wrapped around a 4-bit combinational ALU
module alu_accum_ctrl #(
    parameter int         CNT_W   = 8,
    parameter logic [3:0] ACC_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [2:0]       in_op,
    input  logic [3:0]       in_operand,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [3:0]       alu_result,
    input  logic             alu_zf,
    input  logic             alu_cf,
    input  logic             alu_pf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_acc,
    output logic [2:0]       out_flags,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         acc_q, acc_d;
    logic [2:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         operand_q, operand_d;
    logic [2:0]         opcode_q, opcode_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        opcode_d  = opcode_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    operand_d = in_operand;
                    opcode_d  = in_op;
                    if (in_load) begin
                        acc_d   = in_operand;
                        state_d = RESP;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // ALU outputs are only trusted here, once A/B/opcode have been stable a full cycle
                acc_d   = alu_result;
                flags_d = {alu_zf, alu_cf, alu_pf};
                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= ACC_RST;
            flags_q   <= 3'b000;
            cnt_q     <= '0;
            operand_q <= 4'h0;
            opcode_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            opcode_q  <= opcode_d;
        end
    end

    // Ready depends only on state and reset, never on in_valid
    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == RESP);
    assign alu_a      = acc_q;
    assign alu_b      = operand_q;
    assign alu_opcode = opcode_q;
    assign out_acc    = acc_q;
    assign out_flags  = flags_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// tb/tb_alu_accum_ctrl.sv - self-checking bench for alu_accum_ctrl with a behavioural ALU and transaction model
module tb_alu_accum_ctrl;

    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_load;
    logic [2:0]    in_op;
    logic [3:0]    in_operand;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_opcode;
    logic [3:0]    alu_result;
    logic          alu_zf;
    logic          alu_cf;
    logic          alu_pf;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_acc;
    logic [2:0]    out_flags;
    logic [CW-1:0] op_count;

    alu_accum_ctrl #(.CNT_W(CW), .ACC_RST(4'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_op      (in_op),
        .in_operand (in_operand),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zf     (alu_zf),
        .alu_cf     (alu_cf),
        .alu_pf     (alu_pf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_flags  (out_flags),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 4-bit ALU: C is carry for ADD/INC, borrow for SUB/DEC, 0 for logic ops; P=1 on even parity
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int r;
        int c;
        logic [3:0] res;
        c = 0;
        case (op)
            3'd0: begin r = int'(a) + int'(b); c = (r > 15) ? 1 : 0; end
            3'd1: begin r = int'(a) - int'(b); c = (r < 0) ? 1 : 0; end
            3'd2: begin r = int'(a) + 1;       c = (r > 15) ? 1 : 0; end
            3'd3: begin r = int'(a) - 1;       c = (r < 0) ? 1 : 0; end
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = int'(~a);
        endcase
        res = 4'(r & 15);
        return {res, (res == 4'h0), (c == 1), ~^res};
    endfunction

    always_comb begin
        {alu_result, alu_zf, alu_cf, alu_pf} = alu_f(alu_a, alu_b, alu_opcode);
    end

    int n_pass;
    int n_total;
    bit chk_en;

    logic [3:0] exp_acc;
    logic [2:0] exp_flags;
    int         exp_cnt;
    logic       exp_vld;
    logic       exp_rdy;

    logic [3:0] r_acc;
    logic [2:0] r_flags;
    int         r_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  32'(in_ready),  32'(exp_rdy && !rst));
            chk("out_valid", 32'(out_valid), 32'(exp_vld));
            chk("out_acc",   32'(out_acc),   32'(exp_acc));
            chk("out_flags", 32'(out_flags), 32'(exp_flags));
            chk("op_count",  32'(op_count),  32'(exp_cnt % (1 << CW)));
            chk("alu_a",     32'(alu_a),     32'(exp_acc));
        end
    end

    // All tasks start and end at posedge+1 with the DUT idle
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; in_load = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        exp_acc = 4'h0; exp_flags = 3'b000; exp_cnt = 0; exp_vld = 1'b0; exp_rdy = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic load, input logic [2:0] op, input logic [3:0] v, input int hold);
        logic [6:0] m;
        in_valid = 1'b1; in_load = load; in_op = op; in_operand = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_rdy = 1'b0;
        if (load) begin
            exp_acc = v;
        end else begin
            m = alu_f(exp_acc, v, op);
            @(negedge clk);
            chk("exec_alu_b",      32'(alu_b),      32'(v));
            chk("exec_alu_opcode", 32'(alu_opcode), 32'(op));
            @(posedge clk); #1;
            exp_acc = m[6:3]; exp_flags = m[2:0]; exp_cnt++;
        end
        exp_vld = 1'b1;
        r_acc = out_acc; r_flags = out_flags; r_cnt = int'(op_count);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_load = 1'(i); in_op = 3'(i + 1); in_operand = 4'(9 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_vld = 1'b0; exp_rdy = 1'b1;
    endtask

    int wrap_seq[5];

    initial begin
        wrap_seq = '{1, 2, 3, 0, 1};
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 3'd0; in_operand = 4'h0; out_ready = 1'b0;
        exp_acc = 4'h0; exp_flags = 3'b000; exp_cnt = 0; exp_vld = 1'b0; exp_rdy = 1'b0;
        @(posedge clk); #1;

        do_reset();
        chk("rst_acc", 32'(out_acc), 32'h0);
        chk("rst_cnt", 32'(op_count), 32'h0);

        issue(1'b1, 3'd0, 4'h3, 0);
        issue(1'b0, 3'd0, 4'h5, 0);
        chk("add3_5_acc",   32'(r_acc),   32'h8);
        chk("add3_5_flags", 32'(r_flags), 32'b000);
        chk("add3_5_cnt",   32'(r_cnt),   32'd1);

        issue(1'b1, 3'd0, 4'h5, 0);
        issue(1'b0, 3'd1, 4'h5, 0);
        chk("sub5_5_acc",   32'(r_acc),   32'h0);
        chk("sub5_5_flags", 32'(r_flags), 32'b101);

        issue(1'b1, 3'd0, 4'hC, 0);
        issue(1'b0, 3'd0, 4'h6, 0);
        chk("addC_6_acc",   32'(r_acc),   32'h2);
        chk("addC_6_flags", 32'(r_flags), 32'b010);

        issue(1'b1, 3'd0, 4'h9, 0);
        for (int op = 1; op < 8; op++) issue(1'b0, 3'(op), 4'(op * 3), (op == 3) ? 4 : 0);
        issue(1'b0, 3'd4, 4'h7, 4);
        chk("bp_acc_stable", 32'(out_acc), 32'(r_acc));

        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 3'd0, 4'(i + 1), 0);
            chk("load_no_cnt", 32'(r_cnt), 32'((i == 0) ? 0 : wrap_seq[i - 1]));
            issue(1'b0, 3'd6, 4'h5, 0);
            chk("wrap_cnt", 32'(r_cnt), 32'(wrap_seq[i]));
        end

        issue(1'b1, 3'd0, 4'h7, 0);
        in_valid = 1'b1; in_load = 1'b0; in_op = 3'd0; in_operand = 4'h4;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1; exp_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_acc = 4'h0; exp_flags = 3'b000; exp_cnt = 0; exp_vld = 1'b0; exp_rdy = 1'b1;
        chk("abort_acc", 32'(out_acc),   32'h0);
        chk("abort_cnt", 32'(op_count),  32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_valid", 32'(out_valid), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_accum_ctrl.md
Name: alu_accum_ctrl

Overview:
- Execution controller wrapped around the 4-bit combinational ALU.
- Accepts instructions (opcode + 4-bit operand) over a valid/ready handshake.
- Drives the ALU with the accumulator as A and the operand as B, captures the ALU result and flags into an accumulator and a flag register, then presents them downstream over a second valid/ready handshake.
- Upstream of the ALU (feeds A, B, opcode) and its direct consumer (registers Result, ZF, CF, PF).

Parameters:
- CNT_W, 8, width of the executed-operation counter
- ACC_RST, 4'h0, accumulator value after reset

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  controller can accept an instruction
- in_load  input  1  1 = load operand into accumulator (no ALU op); 0 = ALU op
- in_op  input  3  ALU opcode (000 ADD, 001 SUB, 010 INC, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 NOT A)
- in_operand  input  4  B operand, or load value
- alu_a  output  4  to ALU A, always equals accumulator
- alu_b  output  4  to ALU B, registered operand
- alu_opcode  output  3  to ALU opcode, registered opcode
- alu_result  input  4  from ALU Result
- alu_zf  input  1  from ALU ZF
- alu_cf  input  1  from ALU CF
- alu_pf  input  1  from ALU PF
- out_valid  output  1  accumulator/flags update available
- out_ready  input  1  downstream accepts update
- out_acc  output  4  accumulator value
- out_flags  output  3  {Z, C, P} flag register
- op_count  output  CNT_W  number of completed ALU ops (loads excluded)

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE, accumulator=ACC_RST, flags=000, op_count=0, operand/opcode regs=0, out_valid=0.
  - in_ready is forced 0 while rst=1.
  - Reset mid-operation aborts the instruction: no out_valid, no flag or accumulator update.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch in_op, in_operand, in_load.
  - in_load=0 -> EXEC; in_load=1 -> accumulator<=in_operand, flags unchanged, -> RESP.
- EXEC (exactly 1 cycle):
  - in_ready=0; alu_a/alu_b/alu_opcode stable from registers.
  - At end of cycle: accumulator<=alu_result, flags<={alu_zf, alu_cf, alu_pf}, op_count<=op_count+1 (wraps 2^CNT_W-1 -> 0), -> RESP.
- RESP:
  - out_valid=1; out_acc/out_flags hold the captured values.
  - Held stable while out_ready=0. in_ready=0; in_valid is ignored, with no side effects.
  - On out_valid&out_ready at an edge -> IDLE.
- Latency:
  - ALU op: accept edge at cycle 0, EXEC in cycle 1, out_valid in cycle 2.
  - Load: out_valid in cycle 1.
  - Max throughput is one ALU op per 3 cycles.
- Flags are captured exactly as presented by the ALU; no recomputation or masking by opcode.
- alu_a, alu_b and alu_opcode are driven in all states. Only the EXEC-cycle ALU outputs are sampled.
- out_acc and out_flags always reflect the current registers, including outside RESP.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_acc=0, out_flags=000, op_count=0; in_ready=1 on the first cycle after rst falls.
- LOAD 3 then ADD 5 (bench drives alu_* from a 4-bit ALU model) -> EXEC shows alu_a=3, alu_b=5, alu_opcode=000; out_valid 2 cycles after accept; out_acc=8, out_flags=000, op_count=1.
- LOAD 5 then SUB 5 -> out_acc=0, out_flags=101 (Z=1, C=0, P=1); LOAD 0xC then ADD 6 -> out_acc=2, out_flags=010.
- Backpressure: hold out_ready=0 for 4 cycles in RESP while pulsing in_valid with new ops -> out_valid, out_acc and out_flags stable, in_ready=0, op_count unchanged; out_ready=1 gives one transfer, then IDLE.
- Counter wrap: CNT_W=2, run 5 XOR ops -> op_count sequence 1,2,3,0,1; interleaved loads do not increment it.
- Reset during EXEC of ADD after LOAD 7 -> next cycle out_acc=0, out_flags=000, out_valid never asserted, op_count=0.
